multiplier: RTL and testbench

- Sequential decimal floating-point multiplier for the calculator datapath; the inverse operator of the divider.
- Operand value = (-1)^sign × mant × 10^exp; mant is an unsigned integer, exp is a signed base-10 exponent.
- Uses the same eval/done handshake and operand/result format as the divider, so the calculator FSM can select either unit interchangeably.
- Computes the full-width product, then normalises it iteratively by ÷10 until the mantissa fits in MANT_W bits.

---
 rtl/multiplier_if.sv | 31 +++
 rtl/multiplier.sv | 188 ++++++++++++++++++
 tb/tb_multiplier.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_if.sv
// Operand/result bundle shared by the decimal multiplier and divider.
// The calculator side is the master; the arithmetic unit is the slave.
interface multiplier_if #(
   parameter int MANT_W = 34,
   parameter int EXP_W  = 7
);
   logic                     eval;
   logic                     done;
   logic                     busy;
   logic                     signA;
   logic                     signB;
   logic [MANT_W-1:0]        mantA;
   logic [MANT_W-1:0]        mantB;
   logic signed [EXP_W-1:0]  expA;
   logic signed [EXP_W-1:0]  expB;
   logic                     signRes;
   logic [MANT_W-1:0]        mantRes;
   logic signed [EXP_W-1:0]  expRes;
   logic                     ovf;
   logic                     unf;

   modport master (
      output eval, signA, signB, mantA, mantB, expA, expB,
      input  done, busy, signRes, mantRes, expRes, ovf, unf
   );

   modport slave (
      input  eval, signA, signB, mantA, mantB, expA, expB,
      output done, busy, signRes, mantRes, expRes, ovf, unf
   );
endinterface

// File: rtl/multiplier.sv
// Sequential decimal floating-point multiplier.
// Forms the full-width mantissa product, then divides by ten one step per
// clock until the mantissa fits, and finally saturates or flushes the
// exponent if it falls outside the representable range.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a rising edge on eval; operands latched on it
// ST_MUL  | full-width product, result sign and exponent sum formed
// ST_NORM | divide product by ten per clock until it fits, then finalise
// ST_DONE | result registers valid; done pulses on the next cycle
module multiplier #(
   parameter int                MANT_W = 34,
   parameter int                EXP_W  = 7,
   parameter logic [MANT_W-1:0] M_MAX  = '1
) (
   input  logic       clock,
   input  logic       reset,
   multiplier_if.slave bus
);

   localparam int P_W = 2 * MANT_W;
   localparam int E_W = EXP_W + 2;

   localparam logic [P_W-1:0]          TEN      = P_W'(10);
   localparam logic [P_W-1:0]          PROD_MAX = {{MANT_W{1'b0}}, M_MAX};
   localparam logic signed [E_W-1:0]   E_ONE    = E_W'(1);
   localparam logic signed [E_W-1:0]   E_HI     = E_W'((2 ** (EXP_W - 1)) - 1);
   localparam logic signed [E_W-1:0]   E_LO     = E_W'(-(2 ** (EXP_W - 1)));
   localparam logic signed [EXP_W-1:0] EXP_SAT  = E_HI[EXP_W-1:0];

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_NORM,
      ST_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic                    eval_prev;
   logic                    do_eval;

   logic                    sign_a;
   logic                    sign_b;
   logic [MANT_W-1:0]       mant_a;
   logic [MANT_W-1:0]       mant_b;
   logic signed [EXP_W-1:0] exp_a;
   logic signed [EXP_W-1:0] exp_b;

   logic [P_W-1:0]          mant_a_x;
   logic [P_W-1:0]          mant_b_x;
   logic signed [E_W-1:0]   exp_a_x;
   logic signed [E_W-1:0]   exp_b_x;

   logic [P_W-1:0]          prod;
   logic signed [E_W-1:0]   e;
   logic                    sgn;
   logic                    prod_big;

   logic                    done_r;
   logic                    sign_res;
   logic [MANT_W-1:0]       mant_res;
   logic signed [EXP_W-1:0] exp_res;
   logic                    ovf_r;
   logic                    unf_r;

   // Edges arriving while the unit is busy are simply not acted on.
   assign do_eval  = bus.eval & ~eval_prev;
   assign prod_big = (prod > PROD_MAX);

   assign mant_a_x = {{MANT_W{1'b0}}, mant_a};
   assign mant_b_x = {{MANT_W{1'b0}}, mant_b};
   assign exp_a_x  = {{2{exp_a[EXP_W-1]}}, exp_a};
   assign exp_b_x  = {{2{exp_b[EXP_W-1]}}, exp_b};

   assign bus.done    = done_r;
   assign bus.busy    = (state != ST_IDLE);
   assign bus.signRes = sign_res;
   assign bus.mantRes = mant_res;
   assign bus.expRes  = exp_res;
   assign bus.ovf     = ovf_r;
   assign bus.unf     = unf_r;

   // Previous eval level for rising-edge detection, tracked in every state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         eval_prev <= 1'b0;
      end else begin
         eval_prev <= bus.eval;
      end
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (do_eval) state_nxt = ST_MUL;
         ST_MUL:  state_nxt = ST_NORM;
         ST_NORM: if (!prod_big) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, product/normalisation datapath and result registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         mant_a   <= '0;
         mant_b   <= '0;
         exp_a    <= '0;
         exp_b    <= '0;
         prod     <= '0;
         e        <= '0;
         sgn      <= 1'b0;
         done_r   <= 1'b0;
         sign_res <= 1'b0;
         mant_res <= '0;
         exp_res  <= '0;
         ovf_r    <= 1'b0;
         unf_r    <= 1'b0;
      end else begin
         done_r <= (state == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (do_eval) begin
                  sign_a <= bus.signA;
                  sign_b <= bus.signB;
                  mant_a <= bus.mantA;
                  mant_b <= bus.mantB;
                  exp_a  <= bus.expA;
                  exp_b  <= bus.expB;
               end
            end
            ST_MUL: begin
               prod <= mant_a_x * mant_b_x;
               e    <= exp_a_x + exp_b_x;
               sgn  <= sign_a ^ sign_b;
            end
            ST_NORM: begin
               if (prod_big) begin
                  prod <= prod / TEN;
                  e    <= e + E_ONE;
               end else if (prod == '0) begin
                  // A zero product wins over any exponent condition.
                  mant_res <= '0;
                  exp_res  <= '0;
                  sign_res <= 1'b0;
                  ovf_r    <= 1'b0;
                  unf_r    <= 1'b0;
               end else if (e > E_HI) begin
                  mant_res <= M_MAX;
                  exp_res  <= EXP_SAT;
                  sign_res <= sgn;
                  ovf_r    <= 1'b1;
                  unf_r    <= 1'b0;
               end else if (e < E_LO) begin
                  mant_res <= '0;
                  exp_res  <= '0;
                  sign_res <= 1'b0;
                  ovf_r    <= 1'b0;
                  unf_r    <= 1'b1;
               end else begin
                  mant_res <= prod[MANT_W-1:0];
                  exp_res  <= e[EXP_W-1:0];
                  sign_res <= sgn;
                  ovf_r    <= 1'b0;
                  unf_r    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the decimal multiplier: directed cases plus
// randomized operands against an arithmetic reference model.
module tb_multiplier;

   localparam int          MANT_W = 34;
   localparam int          EXP_W  = 7;
   localparam logic [33:0] M_MAX  = 34'h3_FFFF_FFFF;
   localparam logic [127:0] TEN128 = 128'd10;
   localparam logic [127:0] MAX128 = {94'd0, M_MAX};

   typedef struct {
      logic        sign;
      logic [33:0] mant;
      int          e;
      logic        ovf;
      logic        unf;
      int          n;
   } res_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   multiplier_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

   multiplier #(.MANT_W(MANT_W), .EXP_W(EXP_W), .M_MAX(M_MAX)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   res_t exp_q[$];
   res_t last;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic res_t zero_res();
      res_t r;
      r.sign = 1'b0;
      r.mant = '0;
      r.e    = 0;
      r.ovf  = 1'b0;
      r.unf  = 1'b0;
      r.n    = 0;
      return r;
   endfunction

   // Reference: exact product, decimal truncation until it fits, then range rules.
   function automatic res_t model(input logic sa, input logic sb,
                                  input logic [33:0] ma, input logic [33:0] mb,
                                  input int ea, input int eb);
      logic [127:0] pa;
      logic [127:0] pb;
      logic [127:0] p;
      int           n;
      int           e;
      res_t         r;
      pa = {94'd0, ma};
      pb = {94'd0, mb};
      p  = pa * pb;
      n  = 0;
      while (p > MAX128) begin
         p = p / TEN128;
         n++;
      end
      e = ea + eb + n;
      r = zero_res();
      r.n = n;
      if (p == 128'd0) begin
      end else if (e > 63) begin
         r.sign = sa ^ sb;
         r.mant = M_MAX;
         r.e    = 63;
         r.ovf  = 1'b1;
      end else if (e < -64) begin
         r.unf = 1'b1;
      end else begin
         r.sign = sa ^ sb;
         r.mant = p[33:0];
         r.e    = e;
      end
      return r;
   endfunction

   // Result comparison whenever done is reported.
   always @(negedge clock) begin : compare
      res_t r;
      if (!reset && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_done: got done=1, required 0 with nothing pending at %0t", $time);
         end else begin
            r = exp_q.pop_front();
            chk("signRes", bus.signRes, r.sign);
            chk("mantRes", bus.mantRes, r.mant);
            chk("expRes",  bus.expRes,  r.e);
            chk("ovf",     bus.ovf,     r.ovf);
            chk("unf",     bus.unf,     r.unf);
            last = r;
         end
      end
   end

   task automatic set_ops(input logic sa, input logic sb,
                          input logic [33:0] ma, input logic [33:0] mb,
                          input int ea, input int eb);
      bus.signA = sa;
      bus.signB = sb;
      bus.mantA = ma;
      bus.mantB = mb;
      bus.expA  = 7'(ea);
      bus.expB  = 7'(eb);
   endtask

   // One operation: eval held for 'hold' edges, optional toggling mid-NORM.
   task automatic run_op(input logic sa, input logic sb,
                         input logic [33:0] ma, input logic [33:0] mb,
                         input int ea, input int eb,
                         input int hold, input bit toggle);
      res_t r;
      int   last_k;
      r = model(sa, sb, ma, mb, ea, eb);
      exp_q.push_back(r);
      @(negedge clock);
      set_ops(sa, sb, ma, mb, ea, eb);
      bus.eval = 1'b1;
      last_k = (((3 + r.n) > hold) ? (3 + r.n) : hold) + 2;
      for (int k = 0; k <= last_k; k++) begin
         @(negedge clock);
         if (k == 1) begin
            chk("hold_mantRes", bus.mantRes, last.mant);
            chk("hold_expRes",  bus.expRes,  last.e);
         end
         chk("busy", bus.busy, (k <= 2 + r.n));
         chk("done", bus.done, (k == 3 + r.n));
         if (toggle && k >= 4 && k <= 9) bus.eval = (k % 2 == 0);
         else bus.eval = (k + 1 < hold);
      end
      bus.eval = 1'b0;
      @(negedge clock);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL no_result: got no done, required a result pulse at %0t", $time);
         exp_q.delete();
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_done"},    bus.done,    0);
      chk({tag, "_busy"},    bus.busy,    0);
      chk({tag, "_signRes"}, bus.signRes, 0);
      chk({tag, "_mantRes"}, bus.mantRes, 0);
      chk({tag, "_expRes"},  bus.expRes,  0);
      chk({tag, "_ovf"},     bus.ovf,     0);
      chk({tag, "_unf"},     bus.unf,     0);
   endtask

   initial begin
      res_t r;
      logic [63:0] rnd;
      logic [33:0] ma;
      logic [33:0] mb;
      last = zero_res();
      bus.eval = 1'b0;
      set_ops(1'b0, 1'b0, '0, '0, 0, 0);

      #2;
      chk_zero_outputs("reset");
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Hand-computed anchors for the reference model.
      r = model(1'b0, 1'b0, 34'd3, 34'd4, 0, 0);
      chk("model_case1_mant", r.mant, 12);
      r = model(1'b1, 1'b0, 34'd2, 34'd5, 1, -3);
      chk("model_case2_sign", r.sign, 1);
      chk("model_case2_exp",  r.e,    -2);
      r = model(1'b0, 1'b0, M_MAX, M_MAX, 0, 0);
      chk("model_case3_mant", r.mant, 64'd2951479051);
      chk("model_case3_exp",  r.e,    11);
      chk("model_case3_n",    r.n,    11);

      // Directed cases.
      run_op(1'b0, 1'b0, 34'd3, 34'd4, 0, 0, 1, 1'b0);
      run_op(1'b1, 1'b0, 34'd2, 34'd5, 1, -3, 1, 1'b0);
      run_op(1'b0, 1'b0, M_MAX, M_MAX, 0, 0, 1, 1'b0);
      run_op(1'b0, 1'b1, 34'd0, 34'd12345, 5, -20, 1, 1'b0);
      run_op(1'b0, 1'b0, 34'd7, 34'd1, 63, 10, 1, 1'b0);
      run_op(1'b0, 1'b0, 34'd1, 34'd1, -64, -10, 1, 1'b0);
      run_op(1'b1, 1'b1, 34'd3, 34'd4, 0, 0, 20, 1'b0);
      run_op(1'b0, 1'b1, M_MAX, M_MAX, 0, 0, 1, 1'b1);

      // Reset in the middle of normalisation.
      @(negedge clock);
      set_ops(1'b0, 1'b0, M_MAX, M_MAX, 0, 0);
      bus.eval = 1'b1;
      repeat (6) @(negedge clock);
      #2 reset = 1'b1;
      #1 chk_zero_outputs("midreset");
      bus.eval = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      last = zero_res();
      repeat (20) @(negedge clock);
      run_op(1'b0, 1'b0, 34'd3, 34'd4, 0, 0, 1, 1'b0);

      // Randomized operands.
      for (int i = 0; i < 300; i++) begin
         rnd = {$urandom(), $urandom()};
         case ($urandom_range(0, 3))
            0:       ma = 34'(rnd[3:0]);
            1:       ma = 34'($urandom_range(0, 100000));
            2:       ma = rnd[33:0];
            default: ma = M_MAX;
         endcase
         rnd = {$urandom(), $urandom()};
         case ($urandom_range(0, 3))
            0:       mb = 34'(rnd[3:0]);
            1:       mb = 34'($urandom_range(0, 100000));
            2:       mb = rnd[33:0];
            default: mb = M_MAX - 34'(rnd[7:0]);
         endcase
         run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ma, mb,
                int'($urandom_range(0, 127)) - 64, int'($urandom_range(0, 127)) - 64,
                int'($urandom_range(1, 3)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
